// File: rtl/bitstream_fetch_ctrl.sv
// Packs 16-bit NAL payload words into a 128-bit ring (one-word owr stage, src_ready backpressure) and tracks the parser bit pointer.
// Define EMU_PREV_REMOVE_EN to strip 00 00 03 emulation-prevention bytes and repack through a one-byte hold register.
module bitstream_fetch_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic        flush,
  input  logic        consume_valid,
  input  logic [5:0]  consume_len,
  output logic        consume_ack,
  output logic [15:0] buf_data,
  output logic        buf_we,
  output logic [2:0]  wr_idx,
  output logic [6:0]  pc,
  output logic [7:0]  level,
  output logic        data_ok
);

  logic [15:0] owr;
  logic        owr_v;
  logic        src_take;
  logic        pack_vld;
  logic [15:0] pack_dat;
  logic [7:0]  level_nxt;

  // Writing stops once 112 bits are buffered, so a whole free slot always separates the writer from pc.
  assign buf_we      = owr_v && (level <= 8'd96) && !flush;
  assign buf_data    = owr;
  assign src_ready   = (!owr_v || buf_we) && !flush;
  assign src_take    = src_valid && src_ready;
  assign consume_ack = consume_valid && (consume_len != 6'd0) && (consume_len <= 6'd32) &&
                       ({2'b00, consume_len} <= level) && !flush;
  assign data_ok     = (level >= 8'd32);
  assign level_nxt   = level + (buf_we ? 8'd16 : 8'd0) - (consume_ack ? {2'b00, consume_len} : 8'd0);

`ifdef EMU_PREV_REMOVE_EN
  logic [1:0] zrun_q, zrun_d;
  logic       hold_v_q, hold_v_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] pk_byte;

  // Bytes are walked in stream order (high byte first); at most one word completes per input word.
  always_comb begin
    zrun_d   = zrun_q;
    hold_v_d = hold_v_q;
    hold_d   = hold_q;
    pack_vld = 1'b0;
    pack_dat = 16'h0000;
    pk_byte  = 8'h00;
    for (int i = 0; i < 2; i++) begin
      pk_byte = (i == 0) ? src_data[15:8] : src_data[7:0];
      if (zrun_d == 2'd2 && pk_byte == 8'h03) begin
        zrun_d = 2'd0;
      end else begin
        if (pk_byte == 8'h00)
          zrun_d = (zrun_d == 2'd2) ? 2'd2 : zrun_d + 2'd1;
        else
          zrun_d = 2'd0;
        if (hold_v_d) begin
          pack_vld = 1'b1;
          pack_dat = {hold_d, pk_byte};
          hold_v_d = 1'b0;
        end else begin
          hold_d   = pk_byte;
          hold_v_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zrun_q   <= 2'd0;
      hold_v_q <= 1'b0;
      hold_q   <= 8'h00;
    end else if (flush) begin
      zrun_q   <= 2'd0;
      hold_v_q <= 1'b0;
      hold_q   <= 8'h00;
    end else if (src_take) begin
      zrun_q   <= zrun_d;
      hold_v_q <= hold_v_d;
      hold_q   <= hold_d;
    end
  end
`else
  assign pack_vld = 1'b1;
  assign pack_dat = src_data;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= 7'd0;
      wr_idx <= 3'd0;
      level  <= 8'd0;
      owr    <= 16'h0000;
      owr_v  <= 1'b0;
    end else if (flush) begin
      pc     <= 7'd0;
      wr_idx <= 3'd0;
      level  <= 8'd0;
      owr    <= 16'h0000;
      owr_v  <= 1'b0;
    end else begin
      level <= level_nxt;
      if (consume_ack)
        pc <= pc + {1'b0, consume_len};
      if (buf_we)
        wr_idx <= wr_idx + 3'd1;
      if (src_take && pack_vld) begin
        owr   <= pack_dat;
        owr_v <= 1'b1;
      end else if (buf_we) begin
        owr_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitstream_fetch_ctrl.sv
// Directed bench for bitstream_fetch_ctrl: expected ring writes are queued as stimulus is issued and a
// negedge monitor pops them whenever buf_we is seen; pointer/level checks are made inline.
module tb_bitstream_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic        flush;
  logic        consume_valid;
  logic [5:0]  consume_len;
  logic        consume_ack;
  logic [15:0] buf_data;
  logic        buf_we;
  logic [2:0]  wr_idx;
  logic [6:0]  pc;
  logic [7:0]  level;
  logic        data_ok;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] dat;
    logic [2:0]  idx;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_e;

  bitstream_fetch_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .flush(flush),
    .consume_valid(consume_valid), .consume_len(consume_len), .consume_ack(consume_ack),
    .buf_data(buf_data), .buf_we(buf_we), .wr_idx(wr_idx),
    .pc(pc), .level(level), .data_ok(data_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (reset_n && buf_we) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL ring_write: unexpected write data=%h slot=%0d", buf_data, wr_idx);
      end else begin
        exp_e = exp_q.pop_front();
        if (buf_data !== exp_e.dat || wr_idx !== exp_e.idx) begin
          fails++;
          $display("FAIL ring_write: got data=%h slot=%0d, want data=%h slot=%0d",
                   buf_data, wr_idx, exp_e.dat, exp_e.idx);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_wr(input logic [15:0] d, input logic [2:0] i);
    exp_q.push_back('{dat: d, idx: i});
  endtask

  task automatic chk_state(input string tag, input logic [6:0] e_pc, input logic [7:0] e_lvl,
                           input logic [2:0] e_wr, input logic e_ok);
    @(negedge clk);
    chk({tag, ".pc"}, {9'd0, pc}, {9'd0, e_pc});
    chk({tag, ".level"}, {8'd0, level}, {8'd0, e_lvl});
    chk({tag, ".wr_idx"}, {13'd0, wr_idx}, {13'd0, e_wr});
    chk({tag, ".data_ok"}, {15'd0, data_ok}, {15'd0, e_ok});
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    bit done;
    done = 1'b0;
    src_data  = w;
    src_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      done = src_ready;
      @(posedge clk);
      #1;
    end
    src_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_word: word %h not accepted within 20 cycles", w);
    end
  endtask

  task automatic consume(input logic [5:0] len, input logic exp_ack);
    consume_valid = 1'b1;
    consume_len   = len;
    @(negedge clk);
    chk($sformatf("consume_ack(len=%0d)", len), {15'd0, consume_ack}, {15'd0, exp_ack});
    @(posedge clk);
    #1;
    consume_valid = 1'b0;
    consume_len   = 6'd0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    src_data = 16'h0; src_valid = 1'b0; flush = 1'b0;
    consume_valid = 1'b1; consume_len = 6'd8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.pc", {9'd0, pc}, 16'd0);
    chk("rst.level", {8'd0, level}, 16'd0);
    chk("rst.wr_idx", {13'd0, wr_idx}, 16'd0);
    chk("rst.buf_we", {15'd0, buf_we}, 16'd0);
    chk("rst.buf_data", buf_data, 16'd0);
    chk("rst.consume_ack", {15'd0, consume_ack}, 16'd0);
    chk("rst.data_ok", {15'd0, data_ok}, 16'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    consume_valid = 1'b0; consume_len = 6'd0;
    @(negedge clk);
    chk("post_rst.src_ready", {15'd0, src_ready}, 16'd1);
    @(posedge clk);
    #1;

    // Fill: seven words reach the ring, the eighth waits in owr.
    for (int i = 1; i <= 7; i++) expect_wr(i[15:0], 3'(i - 1));
    for (int i = 1; i <= 8; i++) send_word(i[15:0]);
    @(negedge clk);
    chk("fill.src_ready", {15'd0, src_ready}, 16'd0);
    chk("fill.buf_we", {15'd0, buf_we}, 16'd0);
    chk_state("fill", 7'd0, 8'd112, 3'd7, 1'b1);

    // Freeing 16 bits lets owr drain into slot 7.
    expect_wr(16'h0008, 3'd7);
    consume(6'd16, 1'b1);
    tick(1);
    chk_state("drain7", 7'd16, 8'd112, 3'd0, 1'b1);

    // Down to 48 bits, then illegal lengths are ignored.
    consume(6'd32, 1'b1);
    consume(6'd32, 1'b1);
    consume(6'd33, 1'b0);
    consume(6'd0, 1'b0);
    consume(6'd50, 1'b0);
    chk_state("illegal", 7'd80, 8'd48, 3'd0, 1'b1);

    // Write and consume 16 in the same cycle keep level at 48.
    expect_wr(16'h0009, 3'd0);
    send_word(16'h0009);
    consume(6'd16, 1'b1);
    chk_state("same_cycle", 7'd96, 8'd48, 3'd1, 1'b1);

    // Pointer wrap past bit 127 and the data_ok threshold.
    consume(6'd24, 1'b1);
    expect_wr(16'h000A, 3'd1);
    expect_wr(16'h000B, 3'd2);
    send_word(16'h000A);
    send_word(16'h000B);
    tick(1);
    chk_state("pre_wrap", 7'd120, 8'd56, 3'd3, 1'b1);
    consume(6'd20, 1'b1);
    chk_state("wrap", 7'd12, 8'd36, 3'd3, 1'b1);
    consume(6'd20, 1'b1);
    chk_state("below32", 7'd32, 8'd16, 3'd3, 1'b0);
    consume(6'd17, 1'b0);
    consume(6'd16, 1'b1);
    consume(6'd1, 1'b0);
    chk_state("empty", 7'd48, 8'd0, 3'd3, 1'b0);

    // Flush at level 80 with owr occupied.
    for (int i = 0; i < 5; i++) expect_wr(16'h000C + i[15:0], 3'(3 + i));
    for (int i = 0; i < 5; i++) send_word(16'h000C + i[15:0]);
    tick(1);
    chk_state("pre_flush", 7'd48, 8'd80, 3'd0, 1'b1);
    send_word(16'h0011);
    flush = 1'b1;
    src_valid = 1'b1; src_data = 16'hBEEF;
    consume_valid = 1'b1; consume_len = 6'd8;
    @(negedge clk);
    chk("flush.src_ready", {15'd0, src_ready}, 16'd0);
    chk("flush.buf_we", {15'd0, buf_we}, 16'd0);
    chk("flush.consume_ack", {15'd0, consume_ack}, 16'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; src_valid = 1'b0; consume_valid = 1'b0; consume_len = 6'd0;
    @(negedge clk);
    chk("post_flush.buf_we", {15'd0, buf_we}, 16'd0);
    chk("post_flush.owr_empty", {15'd0, src_ready}, 16'd1);
    chk_state("post_flush", 7'd0, 8'd0, 3'd0, 1'b0);

    // 00 00 | 03 00 straddling a word boundary.
    expect_wr(16'h0000, 3'd0);
`ifdef EMU_PREV_REMOVE_EN
    send_word(16'h0000);
    send_word(16'h0300);
    tick(1);
    chk_state("epb_cross", 7'd0, 8'd16, 3'd1, 1'b0);
`else
    expect_wr(16'h0300, 3'd1);
    send_word(16'h0000);
    send_word(16'h0300);
    tick(1);
    chk_state("epb_cross", 7'd0, 8'd32, 3'd2, 1'b1);
`endif

    // 00 00 03 01 02 03: only the first 03 follows a zero run.
    pulse_flush();
    chk_state("flush2", 7'd0, 8'd0, 3'd0, 1'b0);
    expect_wr(16'h0000, 3'd0);
`ifdef EMU_PREV_REMOVE_EN
    expect_wr(16'h0102, 3'd1);
`else
    expect_wr(16'h0301, 3'd1);
    expect_wr(16'h0203, 3'd2);
`endif
    send_word(16'h0000);
    send_word(16'h0301);
    send_word(16'h0203);
    tick(1);
`ifdef EMU_PREV_REMOVE_EN
    chk_state("epb_repack", 7'd0, 8'd32, 3'd2, 1'b1);
`else
    chk_state("epb_repack", 7'd0, 8'd48, 3'd3, 1'b1);
`endif

    tick(2);
    chk("scoreboard.pending", exp_q.size()[15:0], 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
